// File: rtl/cipher_uart_tx_if.sv
// kcpsm3 port-bus view of the ciphertext UART stage: strobes and ids in,
// status byte and serial line out.
interface cipher_uart_tx_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] status_out;
   logic       tx;
   logic       busy;

   modport master (
      output port_id, out_port, write_strobe, read_strobe,
      input  status_out, tx, busy
   );

   modport slave (
      input  port_id, out_port, write_strobe, read_strobe,
      output status_out, tx, busy
   );
endinterface

// File: rtl/cipher_uart_tx.sv
// Ciphertext output stage: OUTPUT writes land in a circular FIFO that drains
// as 8N1 UART frames (LSB first); a registered status byte supports polling.
module cipher_uart_tx #(
   parameter int         CLK_DIV     = 434,
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] DATA_PORT   = 8'h04,
   parameter logic [7:0] STATUS_PORT = 8'h08
) (
   input  logic             clk,
   input  logic             reset,
   cipher_uart_tx_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e          state_q;
   logic [BW-1:0]   baud_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            tx_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      status_q;

   logic push_req, push_ok, pop, empty, full, baud_end;

   always_comb begin
      push_req = bus.write_strobe && (bus.port_id == DATA_PORT);
      empty    = (count_q == '0);
      full     = (count_q == DEPTH_C);
      pop      = (state_q == IDLE) && !empty;
      // A pop on the same edge frees the slot the push needs.
      push_ok  = push_req && (!full || pop);
      baud_end = (baud_q == BAUD_LAST);

      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);

      ovf_d = ovf_q;
      if (push_req && !push_ok)
         ovf_d = 1'b1;
      else if (bus.read_strobe && (bus.port_id == STATUS_PORT))
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= bus.out_port;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         status_q <= 8'h01;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (pop)     rptr_q <= rptr_q + AW'(1);
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         status_q <= {4'b0000, ovf_q, (state_q != IDLE), full, empty};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  shift_q <= mem_q[rptr_q];
                  tx_q    <= 1'b0;
                  baud_q  <= '0;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_q    <= '0;
                  tx_q      <= shift_q[0];
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_idx_q != 3'd7) begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shift_q[1];
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.status_out = status_q;
endmodule
